// File: rtl/mem_rw_pkg.sv
// Shared widths, FSM state encodings and status codes for the memory command master.
package mem_rw_pkg;

   localparam int unsigned ADDR_W    = 6;
   localparam int unsigned NUM_W     = 4;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BUF_DEPTH = 16;
   localparam int unsigned TMR_W     = 5;
   localparam int unsigned TMO_CYC   = 31;

   localparam logic [3:0] HDR   = 4'd0;
   localparam logic [3:0] ADDR  = 4'd1;
   localparam logic [3:0] WFILL = 4'd2;
   localparam logic [3:0] WREQ  = 4'd3;
   localparam logic [3:0] WSEND = 4'd4;
   localparam logic [3:0] WWAIT = 4'd5;
   localparam logic [3:0] RREQ  = 4'd6;
   localparam logic [3:0] RRECV = 4'd7;
   localparam logic [3:0] DRAIN = 4'd8;
   localparam logic [3:0] STAT  = 4'd9;

   localparam logic [7:0] ST_OK     = 8'h00;
   localparam logic [7:0] ST_ERR    = 8'h80;
   localparam logic [7:0] ST_BADLEN = 8'h90;
   localparam logic [7:0] ST_TMO    = 8'hA0;

   function automatic logic [7:0] err_status(input logic [2:0] code);
      return ST_ERR | {5'b00000, code};
   endfunction

endpackage

// File: rtl/mem_xfer_buf.sv
// 16x8 register FIFO shared by write payload staging and read data return.
module mem_xfer_buf
   import mem_rw_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic [NUM_W-1:0]  count,
   output logic              empty
);

   logic [DATA_W-1:0] mem_q [BUF_DEPTH];
   logic [NUM_W-1:0]  wr_ptr_q;
   logic [NUM_W-1:0]  rd_ptr_q;
   logic [NUM_W-1:0]  cnt_q;
   logic              do_pop;

   assign do_pop = pop && (cnt_q != '0);

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + NUM_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + NUM_W'(1);
         end
         case ({push, do_pop})
            2'b10:   cnt_q <= cnt_q + NUM_W'(1);
            2'b01:   cnt_q <= cnt_q - NUM_W'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = cnt_q;
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/mem_cmd_master.sv
// Parses a byte-serial command stream, drives one controller burst per command and
// returns read data plus a status byte on the response stream.
module mem_cmd_master
   import mem_rw_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_cmd_data,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic              o_wr_req,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [NUM_W-1:0]  o_wr_num_b,
   output logic [DATA_W-1:0] o_wr_data,
   output logic              o_wr_valid,
   input  logic              i_wr_ack,
   input  logic              i_wr_done,
   output logic              o_rd_req,
   output logic [ADDR_W-1:0] o_rd_addr,
   output logic [NUM_W-1:0]  o_rd_num_b,
   output logic              o_rd_done,
   input  logic              i_rd_ack,
   input  logic              i_rd_valid,
   input  logic [DATA_W-1:0] i_rd_data,
   input  logic              i_err,
   input  logic [2:0]        i_err_code,
   output logic              o_err_ack,
   output logic              o_busy
);

   logic [3:0]        state_q, state_d;
   logic              op_q, op_d;
   logic [NUM_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        status_q, status_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              err_ack_q, err_ack_d;
   logic              rd_done_q, rd_done_d;
   logic              ready_en_q;

   logic              buf_push, buf_pop, buf_flush;
   logic [DATA_W-1:0] buf_wdata, buf_rdata;
   logic [NUM_W-1:0]  buf_cnt;
   logic              buf_empty;

   logic              cmd_hs;
   logic              err_zone;
   logic              tmo_hit;
   logic              tmo_take;

   mem_xfer_buf u_buf (
      .clk   (i_clk),
      .rst_n (i_reset),
      .flush (buf_flush),
      .push  (buf_push),
      .wdata (buf_wdata),
      .pop   (buf_pop),
      .rdata (buf_rdata),
      .count (buf_cnt),
      .empty (buf_empty)
   );

   // ready_en_q keeps o_cmd_ready low for the first cycle after reset is sampled.
   assign o_cmd_ready = ready_en_q &&
                        ((state_q == HDR) || (state_q == ADDR) || (state_q == WFILL));
   assign cmd_hs      = i_cmd_valid && o_cmd_ready;
   assign err_zone    = (state_q == WREQ) || (state_q == WSEND) || (state_q == WWAIT) ||
                        (state_q == RREQ) || (state_q == RRECV);
   assign tmo_hit     = (tmr_q == TMR_W'(TMO_CYC - 1));

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      len_d     = len_q;
      addr_d    = addr_q;
      status_d  = status_q;
      tmr_d     = '0;
      err_ack_d = 1'b0;
      rd_done_d = 1'b0;
      buf_push  = 1'b0;
      buf_pop   = 1'b0;
      buf_flush = 1'b0;
      buf_wdata = i_cmd_data;
      tmo_take  = 1'b0;

      case (state_q)
         HDR: begin
            if (cmd_hs) begin
               op_d    = i_cmd_data[7];
               len_d   = i_cmd_data[NUM_W-1:0];
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (cmd_hs) begin
               addr_d = i_cmd_data[ADDR_W-1:0];
               if (len_q == '0) begin
                  status_d = ST_BADLEN;
                  state_d  = STAT;
               end else begin
                  state_d = op_q ? WFILL : RREQ;
               end
            end
         end
         WFILL: begin
            if (cmd_hs) begin
               buf_push = 1'b1;
               if ((buf_cnt + NUM_W'(1)) == len_q) begin
                  state_d = WREQ;
               end
            end
         end
         WREQ: begin
            if (i_wr_ack) begin
               state_d = WSEND;
            end else if (tmo_hit) begin
               tmo_take = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         WSEND: begin
            buf_pop = 1'b1;
            if (buf_cnt == NUM_W'(1)) begin
               state_d = WWAIT;
            end
         end
         WWAIT: begin
            if (i_wr_done) begin
               status_d = ST_OK;
               state_d  = STAT;
            end else if (tmo_hit) begin
               tmo_take = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         RREQ: begin
            if (i_rd_ack) begin
               state_d = RRECV;
            end else if (tmo_hit) begin
               tmo_take = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         RRECV: begin
            if (i_rd_valid) begin
               buf_push  = 1'b1;
               buf_wdata = i_rd_data;
               if ((buf_cnt + NUM_W'(1)) == len_q) begin
                  rd_done_d = 1'b1;
                  state_d   = DRAIN;
               end
            end else if (tmo_hit) begin
               tmo_take = 1'b1;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         DRAIN: begin
            if (i_rsp_ready && !buf_empty) begin
               buf_pop = 1'b1;
               if (buf_cnt == NUM_W'(1)) begin
                  status_d = ST_OK;
                  state_d  = STAT;
               end
            end
         end
         STAT: begin
            if (i_rsp_ready) begin
               state_d = HDR;
            end
         end
         default: state_d = HDR;
      endcase

      if (tmo_take) begin
         status_d  = ST_TMO;
         state_d   = STAT;
         buf_flush = 1'b1;
      end

      // Controller error overrides any ack/done/valid seen in the same cycle.
      if (err_zone && i_err) begin
         status_d  = err_status(i_err_code);
         state_d   = STAT;
         err_ack_d = 1'b1;
         rd_done_d = 1'b0;
         buf_push  = 1'b0;
         buf_pop   = 1'b0;
         buf_flush = 1'b1;
         tmr_d     = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q    <= HDR;
         op_q       <= 1'b0;
         len_q      <= '0;
         addr_q     <= '0;
         status_q   <= '0;
         tmr_q      <= '0;
         err_ack_q  <= 1'b0;
         rd_done_q  <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         len_q      <= len_d;
         addr_q     <= addr_d;
         status_q   <= status_d;
         tmr_q      <= tmr_d;
         err_ack_q  <= err_ack_d;
         rd_done_q  <= rd_done_d;
         ready_en_q <= 1'b1;
      end
   end

   assign o_wr_req    = (state_q == WREQ);
   assign o_wr_addr   = addr_q;
   assign o_wr_num_b  = len_q;
   assign o_wr_valid  = (state_q == WSEND);
   assign o_wr_data   = (state_q == WSEND) ? buf_rdata : '0;

   assign o_rd_req    = (state_q == RREQ);
   assign o_rd_addr   = addr_q;
   assign o_rd_num_b  = len_q;
   assign o_rd_done   = rd_done_q;

   assign o_rsp_valid = ((state_q == DRAIN) && !buf_empty) || (state_q == STAT);
   assign o_rsp_data  = (state_q == DRAIN) ? buf_rdata :
                        (state_q == STAT)  ? status_q  : '0;

   assign o_err_ack   = err_ack_q;
   assign o_busy      = (state_q != HDR);

endmodule
